// File: rtl/gb_breakpoint_unit_pkg.sv
// gb_dbg_pkg: shared debug-path definitions for the breakpoint unit.
//   BP_* : 2-bit slot mode codes as stored in each slot and shown on sel_mode.
//   bp_state_e : control FSM encoding. ST_WSTEP is the second half of a
//                single-step; it waits for the fetch after the stepped one.
package gb_dbg_pkg;

  localparam logic [1:0] BP_DIS   = 2'b00;
  localparam logic [1:0] BP_EXEC  = 2'b01;
  localparam logic [1:0] BP_READ  = 2'b10;
  localparam logic [1:0] BP_WRITE = 2'b11;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_HALTED = 3'd1,
    ST_RESUME = 3'd2,
    ST_STEP   = 3'd3,
    ST_WSTEP  = 3'd4
  } bp_state_e;

endpackage

// File: rtl/gb_breakpoint_unit_if.sv
// gb_breakpoint_unit_if: CPU-side observation bus and halt request.
//   pc / pc_valid        : fetch address and one-cycle fetch-boundary pulse
//   bus_a / bus_rd / wr  : CPU data bus address and cycle qualifiers
//   halt_req             : stop request back to the CPU core
// master = CPU side, slave = breakpoint unit.
interface gb_breakpoint_unit_if #(parameter int ADDR_W = 16);
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic [ADDR_W-1:0] bus_a;
  logic              bus_rd;
  logic              bus_wr;
  logic              halt_req;

  modport master (output pc, pc_valid, bus_a, bus_rd, bus_wr, input halt_req);
  modport slave  (input pc, pc_valid, bus_a, bus_rd, bus_wr, output halt_req);
endinterface

// File: rtl/gb_breakpoint_unit_slot.sv
// gb_bp_slot: one breakpoint slot.
//   we/ptr/data : byte-serial load; ptr 0..NB-1 writes address lanes LSB
//                 first, ptr NB writes the mode from data[1:0].
//   pc.., bus.. : observed CPU activity
//   addr/mode   : stored contents (debugger readback)
//   match       : combinational hit for the current cycle
module gb_bp_slot
  import gb_dbg_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LOAD_W = 8,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PTR_W-1:0]  ptr,
  input  logic [LOAD_W-1:0] data,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] bus_a,
  input  logic              bus_rd,
  input  logic              bus_wr,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        mode,
  output logic              match
);
  localparam int NB = ADDR_W / LOAD_W;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      mode_q <= BP_DIS;
    end else if (we) begin
      if (ptr == PTR_W'(NB)) begin
        mode_q <= data[1:0];
      end else begin
        // Opening a load sequence disarms the slot so a half-written
        // address can never fire.
        if (ptr == '0) mode_q <= BP_DIS;
        for (int b = 0; b < NB; b++)
          if (ptr == PTR_W'(b)) addr_q[b*LOAD_W +: LOAD_W] <= data;
      end
    end
  end

  always_comb begin
    match = 1'b0;
    case (mode_q)
      BP_EXEC:  match = pc_valid && (pc == addr_q);
      BP_READ:  match = bus_rd && (bus_a == addr_q);
      BP_WRITE: match = bus_wr && (bus_a == addr_q);
      default:  match = 1'b0;
    endcase
  end

  assign addr = addr_q;
  assign mode = mode_q;
endmodule

// File: rtl/gb_breakpoint_unit.sv
// gb_breakpoint_unit: NUM_BP-slot breakpoint/watchpoint engine.
//   clk, rst          : Game Boy clock, async active-high reset
//   load_strobe/data  : DIP-switch byte load into slot `sel`
//   sel               : slot being loaded / displayed
//   continue_pulse    : leave HALTED, skip checks on the next fetch
//   step_pulse        : leave HALTED for one instruction
//   cpu (slave)       : pc/bus observation, halt_req back to the CPU
//   hit_slot          : slot of the last breakpoint halt
//   hit_count         : saturating breakpoint-halt count
//   sel_addr/sel_mode : contents of slot `sel`
//   load_ptr          : next byte index of the load sequence
module gb_breakpoint_unit
  import gb_dbg_pkg::*;
#(
  parameter int NUM_BP = 4,
  parameter int ADDR_W = 16,
  parameter int LOAD_W = 8,
  parameter int CNT_W  = 8,
  localparam int SEL_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
  localparam int PTR_W = $clog2(ADDR_W / LOAD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_strobe,
  input  logic [LOAD_W-1:0] load_data,
  input  logic [SEL_W-1:0]  sel,
  input  logic              continue_pulse,
  input  logic              step_pulse,
  gb_breakpoint_unit_if.slave cpu,
  output logic [SEL_W-1:0]  hit_slot,
  output logic [CNT_W-1:0]  hit_count,
  output logic [ADDR_W-1:0] sel_addr,
  output logic [1:0]        sel_mode,
  output logic [PTR_W-1:0]  load_ptr
);
  localparam int NB = ADDR_W / LOAD_W;

  logic [SEL_W-1:0] sel_q;
  logic [PTR_W-1:0] load_ptr_q, load_ptr_d, ptr_eff;

  logic [NUM_BP-1:0][ADDR_W-1:0] slot_addr;
  logic [NUM_BP-1:0][1:0]        slot_mode;
  logic [NUM_BP-1:0]             slot_match;

  bp_state_e        state_q;
  logic             halt_q;
  logic [SEL_W-1:0] hit_slot_q;
  logic [CNT_W-1:0] hit_cnt_q;

  logic             hit_any;
  logic [SEL_W-1:0] hit_idx;

  // A sel change restarts the sequence; a strobe in that same cycle is
  // byte 0 of the newly selected slot.
  always_comb begin
    ptr_eff    = (sel != sel_q) ? '0 : load_ptr_q;
    load_ptr_d = ptr_eff;
    if (load_strobe)
      load_ptr_d = (ptr_eff == PTR_W'(NB)) ? '0 : ptr_eff + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= '0;
      load_ptr_q <= '0;
    end else begin
      sel_q      <= sel;
      load_ptr_q <= load_ptr_d;
    end
  end

  for (genvar i = 0; i < NUM_BP; i++) begin : g_slot
    gb_bp_slot #(
      .ADDR_W (ADDR_W),
      .LOAD_W (LOAD_W),
      .PTR_W  (PTR_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .we       (load_strobe && (sel == SEL_W'(i))),
      .ptr      (ptr_eff),
      .data     (load_data),
      .pc       (cpu.pc),
      .pc_valid (cpu.pc_valid),
      .bus_a    (cpu.bus_a),
      .bus_rd   (cpu.bus_rd),
      .bus_wr   (cpu.bus_wr),
      .addr     (slot_addr[i]),
      .mode     (slot_mode[i]),
      .match    (slot_match[i])
    );
  end

  // Scan high to low so the lowest matching index is the last assignment.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (slot_match[i]) begin
        hit_any = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  // Matches are only acted on in ST_RUN; every other state ignores them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      halt_q     <= 1'b0;
      hit_slot_q <= '0;
      hit_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_RUN: if (hit_any) begin
          state_q    <= ST_HALTED;
          halt_q     <= 1'b1;
          hit_slot_q <= hit_idx;
          if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
        end
        ST_HALTED: begin
          if (step_pulse) begin
            state_q <= ST_STEP;
            halt_q  <= 1'b0;
          end else if (continue_pulse) begin
            state_q <= ST_RESUME;
            halt_q  <= 1'b0;
          end
        end
        // The resuming fetch is deliberately unchecked so an EXEC slot at
        // the halt PC does not immediately re-trigger.
        ST_RESUME: if (cpu.pc_valid) state_q <= ST_RUN;
        ST_STEP:   if (cpu.pc_valid) state_q <= ST_WSTEP;
        ST_WSTEP: if (cpu.pc_valid) begin
          state_q <= ST_HALTED;
          halt_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_RUN;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu.halt_req = halt_q;
  assign hit_slot     = hit_slot_q;
  assign hit_count    = hit_cnt_q;
  assign sel_addr     = slot_addr[sel];
  assign sel_mode     = slot_mode[sel];
  assign load_ptr     = load_ptr_q;
endmodule

// File: tb/tb_gb_breakpoint_unit.sv
module tb_gb_breakpoint_unit;
  import gb_dbg_pkg::*;

  localparam int NUM_BP = 4;
  localparam int ADDR_W = 16;
  localparam int LOAD_W = 8;
  localparam int CNT_W  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_strobe = 1'b0;
  logic [7:0]  load_data = '0;
  logic [1:0]  sel = '0;
  logic        continue_pulse = 1'b0;
  logic        step_pulse = 1'b0;
  logic [1:0]  hit_slot;
  logic [1:0]  hit_count;
  logic [15:0] sel_addr;
  logic [1:0]  sel_mode;
  logic [1:0]  load_ptr;

  always #5 clk = ~clk;

  gb_breakpoint_unit_if #(.ADDR_W(ADDR_W)) cpu ();

  gb_breakpoint_unit #(
    .NUM_BP (NUM_BP),
    .ADDR_W (ADDR_W),
    .LOAD_W (LOAD_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .load_strobe    (load_strobe),
    .load_data      (load_data),
    .sel            (sel),
    .continue_pulse (continue_pulse),
    .step_pulse     (step_pulse),
    .cpu            (cpu),
    .hit_slot       (hit_slot),
    .hit_count      (hit_count),
    .sel_addr       (sel_addr),
    .sel_mode       (sel_mode),
    .load_ptr       (load_ptr)
  );

  typedef struct {
    string      tag;
    logic       halt;
    logic [1:0] slot;
    logic [1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   hits = 0;           // breakpoint halts seen by the model
  logic [1:0] last_slot = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic halt);
    exp_t e;
    e.tag  = tag;
    e.halt = halt;
    e.slot = last_slot;
    e.cnt  = (hits > 3) ? 2'd3 : 2'(hits);
    sbq.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({e.tag, ".halt"}, 32'(cpu.halt_req), 32'(e.halt));
      chk({e.tag, ".slot"}, 32'(hit_slot), 32'(e.slot));
      chk({e.tag, ".cnt"},  32'(hit_count), 32'(e.cnt));
    end
  endtask

  task automatic fetch(input string tag, input logic [15:0] a, input logic halt);
    cpu.pc = a; cpu.pc_valid = 1'b1;
    expect_out(tag, halt);
    tick();
    cpu.pc_valid = 1'b0;
    sb_drain();
  endtask

  task automatic busop(input string tag, input logic [15:0] a, input logic rd,
                       input logic wr, input logic halt);
    cpu.bus_a = a; cpu.bus_rd = rd; cpu.bus_wr = wr;
    expect_out(tag, halt);
    tick();
    cpu.bus_rd = 1'b0; cpu.bus_wr = 1'b0;
    sb_drain();
  endtask

  task automatic ctrl(input string tag, input logic c, input logic s, input logic halt);
    continue_pulse = c; step_pulse = s;
    expect_out(tag, halt);
    tick();
    continue_pulse = 1'b0; step_pulse = 1'b0;
    sb_drain();
  endtask

  task automatic load(input logic [1:0] s, input logic [15:0] a, input logic [1:0] m);
    sel = s;
    load_strobe = 1'b1;
    load_data = a[7:0];  tick();
    load_data = a[15:8]; tick();
    load_data = {6'b0, m}; tick();
    load_strobe = 1'b0;
    chk("ld.addr", 32'(sel_addr), 32'(a));
    chk("ld.mode", 32'(sel_mode), 32'(m));
    chk("ld.ptr",  32'(load_ptr), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu.pc = '0; cpu.pc_valid = 1'b0;
    cpu.bus_a = '0; cpu.bus_rd = 1'b0; cpu.bus_wr = 1'b0;
    tick(); tick();
    expect_out("reset", 1'b0);
    sb_drain();
    chk("reset.ptr",  32'(load_ptr), 32'd0);
    chk("reset.mode", 32'(sel_mode), 32'd0);
    chk("reset.addr", 32'(sel_addr), 32'd0);
    rst = 1'b0;
    tick();

    // Exec breakpoint on slot 1 at 0x0150
    load(2'd1, 16'h0150, BP_EXEC);
    fetch("exec.miss", 16'h0100, 1'b0);
    hits++; last_slot = 2'd1;
    fetch("exec.hit", 16'h0150, 1'b1);

    // Continue: resuming fetch at 0x0150 is skipped, the next one halts
    ctrl("cont", 1'b1, 1'b0, 1'b0);
    fetch("resume.skip", 16'h0150, 1'b0);
    hits++;
    fetch("resume.rehit", 16'h0150, 1'b1);

    // Single step: halts after the second fetch, no count change
    ctrl("step", 1'b0, 1'b1, 1'b0);
    fetch("step.f1", 16'h0152, 1'b0);
    fetch("step.f2", 16'h0153, 1'b1);
    ctrl("cont2", 1'b1, 1'b0, 1'b0);
    fetch("run.again", 16'h0153, 1'b0);
    ctrl("cont.inrun", 1'b1, 1'b0, 1'b0);

    // Write watchpoint on slot 0
    load(2'd0, 16'hFF40, BP_WRITE);
    busop("wp.rd", 16'hFF40, 1'b1, 1'b0, 1'b0);
    busop("wp.wr.other", 16'hFF41, 1'b0, 1'b1, 1'b0);
    hits++; last_slot = 2'd0;
    busop("wp.wr", 16'hFF40, 1'b0, 1'b1, 1'b1);
    ctrl("cont3", 1'b1, 1'b0, 1'b0);
    fetch("resume3", 16'h0200, 1'b0);
    fetch("run3", 16'h0201, 1'b0);

    // Priority: slots 2 and 3 both exec 0x0100, counter saturates
    load(2'd2, 16'h0100, BP_EXEC);
    load(2'd3, 16'h0100, BP_EXEC);
    hits++; last_slot = 2'd2;
    fetch("prio", 16'h0100, 1'b1);

    // Reload while halted keeps the halt
    load(2'd3, 16'h1234, BP_READ);
    expect_out("halt.keep", 1'b1);
    sb_drain();
    ctrl("cont4", 1'b1, 1'b0, 1'b0);
    fetch("resume4", 16'h0100, 1'b0);
    hits++;
    fetch("sat", 16'h0100, 1'b1);

    // Step and continue together: step wins
    ctrl("step+cont", 1'b1, 1'b1, 1'b0);
    fetch("sc.f1", 16'h0101, 1'b0);
    fetch("sc.f2", 16'h0102, 1'b1);
    ctrl("cont5", 1'b1, 1'b0, 1'b0);
    fetch("resume5", 16'h0300, 1'b0);

    // Partial load on slot 1 then sel change
    sel = 2'd1;
    load_strobe = 1'b1;
    load_data = 8'h77; tick();
    load_data = 8'h66; tick();
    load_strobe = 1'b0;
    chk("part.ptr2", 32'(load_ptr), 32'd2);
    chk("part.mode", 32'(sel_mode), 32'(BP_DIS));
    sel = 2'd0; tick();
    chk("part.ptr0", 32'(load_ptr), 32'd0);
    sel = 2'd1; tick();
    chk("part.back.ptr",  32'(load_ptr), 32'd0);
    chk("part.back.mode", 32'(sel_mode), 32'(BP_DIS));
    chk("part.back.addr", 32'(sel_addr), 32'h6677);
    fetch("part.old", 16'h0150, 1'b0);
    fetch("part.new", 16'h6677, 1'b0);

    // Async reset while halted and mid-load
    hits++; last_slot = 2'd2;
    fetch("pre.rst", 16'h0100, 1'b1);
    sel = 2'd0;
    load_strobe = 1'b1; load_data = 8'h11; tick();
    load_strobe = 1'b0;
    chk("pre.rst.ptr", 32'(load_ptr), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    hits = 0; last_slot = '0;
    expect_out("rst.async", 1'b0);
    sb_drain();
    chk("rst.ptr", 32'(load_ptr), 32'd0);
    for (int s = 0; s < NUM_BP; s++) begin
      sel = 2'(s);
      #1;
      chk($sformatf("rst.mode%0d", s), 32'(sel_mode), 32'(BP_DIS));
      chk($sformatf("rst.addr%0d", s), 32'(sel_addr), 32'd0);
    end
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gb_breakpoint_unit.md
# gb_breakpoint_unit

Parametrised multi-slot breakpoint/watchpoint engine for the Game Boy debug path. It holds `NUM_BP` address comparators, each loaded byte-serially from the board DIP switches via a debounced button strobe. Each slot matches instruction fetches, bus reads or bus writes. On a hit the unit raises `halt_req` to the CPU core and supports continue and single-step. It sits between the `button` instances and `gameboy` and supersedes the single 16-bit execute breakpoint register.

## Interface
Parameters:
- `NUM_BP`, 4: number of breakpoint slots (1..16).
- `ADDR_W`, 16: compared address width; must be a multiple of `LOAD_W`.
- `LOAD_W`, 8: width of `load_data` (DIP switch bank).
- `CNT_W`, 8: width of the saturating hit counter.

Ports:
- `clk`, in, 1: Game Boy clock (`clk_gb`).
- `rst`, in, 1: reset, asynchronous, active-high.
- `load_strobe`, in, 1: one-cycle pulse; writes `load_data` into the selected slot.
- `load_data`, in, `LOAD_W`: byte to load.
- `sel`, in, `$clog2(NUM_BP)`: slot being loaded/displayed.
- `pc`, in, `ADDR_W`: current PC.
- `pc_valid`, in, 1: one-cycle pulse at each instruction fetch boundary.
- `bus_a`, in, `ADDR_W`: CPU bus address.
- `bus_rd`, in, 1: bus read cycle.
- `bus_wr`, in, 1: bus write cycle.
- `continue_pulse`, in, 1: resume from halt.
- `step_pulse`, in, 1: execute exactly one instruction, then halt.
- `halt_req`, out, 1: request to the CPU to stop; reset 0.
- `hit_slot`, out, `$clog2(NUM_BP)`: slot that caused the last halt; reset 0.
- `hit_count`, out, `CNT_W`: saturating number of breakpoint halts; reset 0.
- `sel_addr`, out, `ADDR_W`: stored address of slot `sel` (for the debugger); reset 0.
- `sel_mode`, out, 2: stored mode of slot `sel`; reset 0.
- `load_ptr`, out, `$clog2(ADDR_W/LOAD_W+1)`: next byte index; reset 0.

## Operation
- Slot mode values: 00 DISABLED, 01 EXEC, 10 READ, 11 WRITE. All slots reset to address 0, mode DISABLED.
- Loading takes `K = ADDR_W/LOAD_W + 1` strobes, with bytes 0..K-2 written to the address LSB-first and byte K-1 written to the mode from bits[1:0].
  - The first strobe of a sequence also forces the slot's mode to DISABLED, so a half-written slot never matches.
  - `load_ptr` increments per strobe and wraps to 0 after byte K-1.
  - Any change of `sel` resets `load_ptr` to 0; it does not alter stored contents.
- Match conditions:
  - Slot i EXEC matches when `pc_valid && pc == addr_i`.
  - READ matches when `bus_rd && bus_a == addr_i`.
  - WRITE matches when `bus_wr && bus_a == addr_i`.
- When several slots match in one cycle, the lowest index wins.
- Control FSM states: RUN, HALTED, RESUME, STEP.
  - RUN: any match -> HALTED; latch `hit_slot`; increment `hit_count`, saturating at all-ones.
  - HALTED: `step_pulse` -> STEP; otherwise `continue_pulse` -> RESUME. Step wins when both arrive together.
  - RESUME: all matches are suppressed; the next `pc_valid` -> RUN. That fetch itself is not checked, so resuming at an EXEC address does not re-trigger.
  - STEP: matches are suppressed; the first `pc_valid` -> WSTEP (a sub-state of STEP); the second `pc_valid` -> HALTED. Step halts do not change `hit_slot` or `hit_count`.
- `halt_req` is 1 in HALTED, else 0.
- A `load_strobe` in any state is honoured. A slot rewritten while HALTED does not release the halt.

## Timing
- Match-to-`halt_req` latency is 1 cycle: comparison is combinational and the FSM state is registered.
- `hit_slot` and `hit_count` update on the same edge that `halt_req` rises.
- A `load_strobe` is visible on `sel_addr`/`sel_mode` the following cycle. A new mode can match from the cycle after the final strobe.
- `continue_pulse`/`step_pulse` are single-cycle; pulses in RUN, RESUME or STEP are ignored.
- Asynchronous `rst` mid-load or mid-halt returns every output and slot to its reset value immediately.

## Structure
- Shared package `gb_dbg_pkg`: mode constants (`BP_DIS`, `BP_EXEC`, `BP_READ`, `BP_WRITE`) and FSM state encodings (RUN, HALTED, RESUME, STEP, WSTEP).
- Sub-module `gb_bp_slot`: one slot's address/mode storage, byte-lane write, and a one-bit `match` output. It is instantiated `NUM_BP` times in a generate loop.
- The top level holds the load pointer, priority encoder, FSM and counter.

## Test plan
- Load and exec hit: slot 1 loaded 0x50, 0x01, 0x01; `pc_valid` with pc=0x0150 -> `halt_req`=1 next cycle, `hit_slot`=1, `hit_count`=1.
- Watchpoints:
  - slot 0 WRITE 0xFF40; `bus_rd` at 0xFF40 -> no halt.
  - `bus_wr` at 0xFF40 -> halt, `hit_slot`=0.
- Priority and saturation:
  - slots 2 and 3 both EXEC 0x0100 -> `hit_slot`=2.
  - with `CNT_W`=2, 5 hits -> `hit_count`=3.
- Continue and step:
  - continue at exec BP 0x0150 -> no re-halt on the 0x0150 fetch; next fetch at 0x0150 later halts.
  - step: `halt_req` drops, then rises after the second `pc_valid`; `hit_count` unchanged.
- Partial load: 2 strobes, then `sel` change -> `load_ptr`=0, original slot mode=DISABLED, no match on its old address.
- `rst` asserted while HALTED and mid-load -> `halt_req`=0, `hit_count`=0, all modes DISABLED within the same cycle.
